// File: rtl/noc_pkg.sv
// Shared constants and state encoding for the NoC configuration scheduler.
package noc_pkg;
  localparam int CFG_W     = 11;
  localparam int NUM_PORTS = 4;
  localparam int TMO_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLOCK = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick: first requester at or after ptr, wrapping 3 -> 0.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_id,
  output logic       any
);
  logic [1:0] idx;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_id = ptr;
    any    = 1'b0;
    idx    = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        gnt_id = idx;
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_cfg_sched.sv
// Serialises mesh port reconfiguration: grant one requester, quiesce the mesh,
// hold its configure word, then wait for that port's ready (or give up).
module noc_cfg_sched #(
  parameter int CFG_W       = noc_pkg::CFG_W,
  parameter int HOLD_CYCLES = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         req_valid,
  input  logic [4*CFG_W-1:0] req_cfg,
  output logic [3:0]         req_ack,
  input  logic [3:0]         processor_ready_signals,
  input  logic               block_in,
  output logic [CFG_W-1:0]   p0_configure,
  output logic [CFG_W-1:0]   p1_configure,
  output logic [CFG_W-1:0]   p2_configure,
  output logic [CFG_W-1:0]   p3_configure,
  output logic               block_all_paths,
  output logic               busy,
  output logic [1:0]         grant_id,
  output logic               done,
  output logic               timeout_err,
  output logic [1:0]         dbg_state,
  output logic [1:0]         dbg_rr_ptr
);
  import noc_pkg::*;

  localparam logic [TMO_W-1:0] HOLD_LAST = TMO_W'(HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIM   = TMO_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         rr_q, rr_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [3:0]         ack_q, ack_d;
  logic               done_q, done_d, tmo_q, tmo_d;
  logic               block_q, block_d, busy_q, busy_d;
  logic [CFG_W-1:0]   pcfg_q [NUM_PORTS];
  logic [CFG_W-1:0]   pcfg_d [NUM_PORTS];

  logic [1:0]         arb_gnt;
  logic               arb_any;
  logic [CFG_W-1:0]   req_word;

  rr_arbiter4 u_arb (
    .req    (req_valid),
    .ptr    (rr_q),
    .gnt_id (arb_gnt),
    .any    (arb_any)
  );

  assign req_word = req_cfg[arb_gnt*CFG_W +: CFG_W];

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!block_in && arb_any) begin
          ack_d   = 4'b0001 << arb_gnt;
          grant_d = arb_gnt;
          cfg_d   = req_word;
          cnt_d   = '0;
          // An all-zero word is acknowledged but never reaches the mesh.
          if (req_word != '0) state_d = ST_BLOCK;
          else                rr_d    = arb_gnt + 2'd1;
        end
      end
      ST_BLOCK: begin
        state_d = ST_ISSUE;
        cnt_d   = '0;
      end
      ST_ISSUE: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT: begin
        if (processor_ready_signals[grant_q]) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          rr_d    = grant_q + 2'd1;
        end else if (cnt_inc == TMO_LIM) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
          rr_d    = grant_q + 2'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    block_d = block_in || (state_d == ST_BLOCK) || (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
    for (int i = 0; i < NUM_PORTS; i++) begin
      pcfg_d[i] = ((state_d == ST_ISSUE) && (grant_d == 2'(i))) ? cfg_d : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      block_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) pcfg_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      block_q <= block_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NUM_PORTS; i++) pcfg_q[i] <= pcfg_d[i];
    end
  end

  assign req_ack         = ack_q;
  assign p0_configure    = pcfg_q[0];
  assign p1_configure    = pcfg_q[1];
  assign p2_configure    = pcfg_q[2];
  assign p3_configure    = pcfg_q[3];
  assign block_all_paths = block_q;
  assign busy            = busy_q;
  assign grant_id        = grant_q;
  assign done            = done_q;
  assign timeout_err     = tmo_q;
  assign dbg_state       = state_q;
  assign dbg_rr_ptr      = rr_q;
endmodule

// File: tb/tb_noc_cfg_sched.sv
// Bench for noc_cfg_sched: directed scenarios plus random traffic, all checked
// each cycle against a timeline model of a transaction.
module tb_noc_cfg_sched;
  localparam int CFG_W = 11;
  localparam int HOLD  = 3;
  localparam int TMO   = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [3:0]         req_valid = '0;
  logic [4*CFG_W-1:0] req_cfg = '0;
  logic [3:0]         req_ack;
  logic [3:0]         ready = '0;
  logic               block_in = 1'b0;
  logic [CFG_W-1:0]   p0, p1, p2, p3;
  logic               block_all_paths, busy, done, timeout_err;
  logic [1:0]         grant_id, dbg_state, dbg_rr_ptr;

  always #5 clock = ~clock;

  noc_cfg_sched #(.CFG_W(CFG_W), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_cfg(req_cfg),
    .req_ack(req_ack), .processor_ready_signals(ready), .block_in(block_in),
    .p0_configure(p0), .p1_configure(p1), .p2_configure(p2), .p3_configure(p3),
    .block_all_paths(block_all_paths), .busy(busy), .grant_id(grant_id),
    .done(done), .timeout_err(timeout_err), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // Model: a transaction is described by its age in cycles since the grant edge.
  // age 1 = quiesce cycle, 2..1+HOLD = hold window, beyond that = waiting.
  logic             m_active;
  int               m_age, m_g, m_rr;
  logic [CFG_W-1:0] m_word;
  logic [3:0]       e_ack;
  logic             e_done, e_tmo, e_blk;
  logic             hold_req = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_age = 0; m_g = 0; m_rr = 0; m_word = '0;
    e_ack = '0; e_done = 1'b0; e_tmo = 1'b0; e_blk = 1'b0;
  endtask

  task automatic model_step();
    int g;
    e_blk = block_in; e_ack = '0; e_done = 1'b0; e_tmo = 1'b0;
    if (!m_active) begin
      if (!block_in && req_valid != 4'd0) begin
        g = -1;
        for (int k = 0; k < 4; k++)
          if (g < 0 && req_valid[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        e_ack[g] = 1'b1;
        m_g      = g;
        m_word   = req_cfg[g*CFG_W +: CFG_W];
        if (m_word != '0) begin m_active = 1'b1; m_age = 1; end
        else m_rr = (g + 1) % 4;
      end
    end else if (m_age <= 1 + HOLD) begin
      m_age++;
    end else if (ready[m_g]) begin
      e_done = 1'b1; m_active = 1'b0; m_rr = (m_g + 1) % 4;
    end else if (m_age - (1 + HOLD) == TMO) begin
      e_tmo = 1'b1; m_active = 1'b0; m_rr = (m_g + 1) % 4;
    end else begin
      m_age++;
    end
  endtask

  function automatic logic [63:0] exp_vec();
    logic [1:0]       st;
    logic             in_hold;
    logic [CFG_W-1:0] pc [4];
    in_hold = m_active && m_age >= 2 && m_age <= 1 + HOLD;
    st = !m_active ? 2'd0 : (m_age == 1) ? 2'd1 : (m_age <= 1 + HOLD) ? 2'd2 : 2'd3;
    for (int i = 0; i < 4; i++) pc[i] = (in_hold && m_g == i) ? m_word : '0;
    return {6'd0, e_ack, e_blk || (m_active && m_age <= 1 + HOLD), m_active, 2'(m_g),
            e_done, e_tmo, st, 2'(m_rr), pc[3], pc[2], pc[1], pc[0]};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {6'd0, req_ack, block_all_paths, busy, grant_id, done, timeout_err,
            dbg_state, dbg_rr_ptr, p3, p2, p1, p0};
  endfunction

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("cycle", dut_vec(), exp_vec());
    if (!hold_req) req_valid = req_valid & ~e_ack;
  endtask

  task automatic set_word(input int port, input logic [CFG_W-1:0] w);
    req_cfg[port*CFG_W +: CFG_W] = w;
  endtask

  task automatic drain();
    int c;
    req_valid = '0; ready = 4'hF; block_in = 1'b0; c = 0;
    while (m_active && c < 64) begin cycle(); c++; end
    check("drain_idle", m_active, 1'b0);
    ready = '0;
  endtask

  int ack_at, n_ack, n_blk, n_p0, n_done, n_other, w, e_at, x_at, lat;
  int order [$];

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_outputs", dut_vec(), 64'd0);
    reset = 1'b1;

    // Single request with ready arriving 5 cycles into WAIT.
    set_word(0, 11'b01000000101); req_valid = 4'b0001;
    ack_at = -1; n_ack = 0; n_blk = 0; n_p0 = 0; n_done = 0; n_other = 0; w = 0;
    for (int c = 0; c < 20; c++) begin
      if (w >= 5) ready[0] = 1'b1;
      cycle();
      if (req_ack[0]) begin n_ack++; if (ack_at < 0) ack_at = c; end
      if (block_all_paths) n_blk++;
      if (p0 == 11'h205) n_p0++;
      if (done) n_done++;
      if ((p1 | p2 | p3) != '0) n_other++;
      if (m_active && m_age >= 2 + HOLD) w++;
    end
    ready = '0;
    check("single_ack_lat", ack_at, 0);
    check("single_ack_cnt", n_ack, 1);
    check("single_block_cnt", n_blk, 4);
    check("single_p0_cnt", n_p0, 3);
    check("single_done_cnt", n_done, 1);
    check("single_other_cfg", n_other, 0);

    // Round-robin between ports 1 and 3, requests held, ready immediate.
    set_word(1, 11'b01000000001); set_word(3, 11'b01000000001);
    hold_req = 1'b1; req_valid = 4'b1010; ready = 4'hF; n_other = 0;
    order.delete();
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      cycle();
      for (int i = 0; i < 4; i++) if (req_ack[i]) order.push_back(i);
      if (((p0 != '0) + (p1 != '0) + (p2 != '0) + (p3 != '0)) > 1) n_other++;
    end
    hold_req = 1'b0;
    check("rr_ack_count", order.size(), 4);
    while (order.size() < 4) order.push_back(-1);
    check("rr_order0", order[0], 1);
    check("rr_order1", order[1], 3);
    check("rr_order2", order[2], 1);
    check("rr_order3", order[3], 3);
    check("rr_one_port", n_other, 0);
    drain();

    // Timeout on port 2 with ready never rising.
    set_word(2, 11'h123); req_valid = 4'b0100; ready = '0;
    e_at = -1; x_at = -1;
    for (int c = 0; c < 40 && x_at < 0; c++) begin
      cycle();
      if (dbg_state == 2'd3 && e_at < 0) e_at = c;
      if (timeout_err) begin
        x_at = c;
        check("tmo_rr_ptr", dbg_rr_ptr, 2'd3);
        check("tmo_busy", busy, 1'b0);
      end
    end
    check("tmo_latency", x_at - e_at, TMO);

    // Zero word on port 0 is dropped; port 1 is granted straight after.
    set_word(0, '0); set_word(1, 11'h155); req_valid = 4'b0011;
    cycle();
    check("zero_ack0", {req_ack, dbg_state}, {4'b0001, 2'd0});
    cycle();
    check("zero_ack1", {req_ack, dbg_state}, {4'b0010, 2'd1});
    drain();

    // Reset asserted in the second hold cycle.
    set_word(0, 11'h3ff); req_valid = 4'b0001;
    for (int c = 0; c < 10 && !(m_active && m_age == 3); c++) cycle();
    check("rstmid_reached", p0, 11'h3ff);
    reset = 1'b0; req_valid = '0;
    #1;
    check("rstmid_outputs", {p3, p2, p1, p0, block_all_paths, busy}, 0);
    @(negedge clock);
    reset = 1'b1; model_reset();
    check("rstmid_state", dbg_state, 2'd0);

    // External freeze holds off a pending request.
    set_word(2, 11'h0aa); block_in = 1'b1; req_valid = 4'b0100;
    n_ack = 0; n_blk = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (req_ack != '0) n_ack++;
      if (block_all_paths) n_blk++;
    end
    check("blk_no_ack", n_ack, 0);
    check("blk_paths_high", n_blk, 6);
    block_in = 1'b0; lat = -1;
    for (int c = 1; c <= 4 && lat < 0; c++) begin
      cycle();
      if (req_ack[2]) lat = c;
    end
    check("blk_release_ack", (lat >= 1 && lat <= 2), 1'b1);
    drain();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          set_word(i, ($urandom_range(0, 3) == 0) ? '0 : CFG_W'($urandom));
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 39) == 0) begin
          req_valid[i] = 1'b0;
        end
        ready[i] = ($urandom_range(0, 3) == 0);
      end
      block_in = ($urandom_range(0, 19) == 0);
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
